// File: rtl/pll_phase_stepper.sv
// Issues PLL dynamic phase-shift steps: setup, phasestep pulse, phasedone handshake per step,
// with a per-edge timeout. Status is reported as busy / done pulse / sticky error.
module pll_phase_stepper #(
  parameter int STEP_HOLD    = 2,
  parameter int SETUP_CYCLES = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_steps,
  input  logic [2:0] i_counter_sel,
  input  logic       i_updown,
  input  logic       i_phasedone,
  output logic       o_phasestep,
  output logic       o_phaseupdown,
  output logic [2:0] o_phasecounterselect,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  output logic [7:0] o_steps_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STEP,
    ST_WAIT_LO,
    ST_WAIT_HI,
    ST_NEXT,
    ST_DONE
  } state_t;

  // One cycle counter serves SETUP, STEP and both WAIT states; all limits fit in 8 bits.
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(STEP_HOLD - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             start_q;
  logic             pd_meta;
  logic             pd_sync;
  logic [7:0]       steps_lat;

  logic start_edge;
  logic accept;
  logic wait_expired;
  logic timeout_hit;

  assign start_edge   = i_start & ~start_q;
  assign accept       = start_edge && (state_q == ST_IDLE);
  assign wait_expired = (cnt_q == TIMEOUT_LAST);
  assign timeout_hit  = wait_expired &&
                        (((state_q == ST_WAIT_LO) &&  pd_sync) ||
                         ((state_q == ST_WAIT_HI) && !pd_sync));

  // State register.
  // NOTE: every clocked block uses <= so all flops update from pre-edge values,
  // independent of the order in which the simulator evaluates the blocks.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = (i_steps == '0) ? ST_DONE : ST_SETUP;
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) state_d = ST_STEP;
      end
      ST_STEP: begin
        if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!pd_sync)         state_d = ST_WAIT_HI;
        else if (timeout_hit) state_d = ST_DONE;
      end
      ST_WAIT_HI: begin
        if (pd_sync)          state_d = ST_NEXT;
        else if (timeout_hit) state_d = ST_DONE;
      end
      ST_NEXT: begin
        state_d = (o_steps_done == steps_lat) ? ST_DONE : ST_STEP;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore outputs; reset forces IDLE, so phasestep drops on the reset edge.
  always_comb begin
    o_phasestep = (state_q == ST_STEP);
    o_busy      = (state_q != ST_IDLE);
    o_done      = (state_q == ST_DONE);
  end

  // Phasedone synchronizer and start edge history.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pd_meta <= 1'b0;
      pd_sync <= 1'b0;
      start_q <= 1'b0;
    end else begin
      pd_meta <= i_phasedone;
      pd_sync <= pd_meta;
      start_q <= i_start;
    end
  end

  // Per-state cycle counter: restarts on every state change and saturates.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                 cnt_q <= '0;
    else if (state_d != state_q)  cnt_q <= '0;
    else if (cnt_q != CNT_MAX)    cnt_q <= cnt_q + 1'b1;
  end

  // Request latches and status. The pin registers double as the select/direction
  // latches, so a zero-step request leaves the PLL pins untouched.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      steps_lat            <= '0;
      o_phasecounterselect <= '0;
      o_phaseupdown        <= 1'b0;
      o_steps_done         <= '0;
      o_error              <= 1'b0;
    end else if (accept) begin
      steps_lat    <= i_steps;
      o_steps_done <= '0;
      o_error      <= 1'b0;
      if (i_steps != '0) begin
        o_phasecounterselect <= i_counter_sel;
        o_phaseupdown        <= i_updown;
      end
    end else begin
      if ((state_q == ST_WAIT_HI) && pd_sync) o_steps_done <= o_steps_done + 1'b1;
      if (timeout_hit)                        o_error      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Self-checking bench for pll_phase_stepper: table of requests against a behavioural PLL,
// with a scoreboard of expected results popped on each done pulse.
module tb_pll_phase_stepper;

  localparam int BUDGET = 5000;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_start;
  logic [7:0] i_steps;
  logic [2:0] i_counter_sel;
  logic       i_updown;
  logic       i_phasedone;
  logic       o_phasestep;
  logic       o_phaseupdown;
  logic [2:0] o_phasecounterselect;
  logic       o_busy;
  logic       o_done;
  logic       o_error;
  logic [7:0] o_steps_done;

  always #5 clk = ~clk;

  pll_phase_stepper dut (
    .i_clk               (clk),
    .i_rst_n             (i_rst_n),
    .i_start             (i_start),
    .i_steps             (i_steps),
    .i_counter_sel       (i_counter_sel),
    .i_updown            (i_updown),
    .i_phasedone         (i_phasedone),
    .o_phasestep         (o_phasestep),
    .o_phaseupdown       (o_phaseupdown),
    .o_phasecounterselect(o_phasecounterselect),
    .o_busy              (o_busy),
    .o_done              (o_done),
    .o_error             (o_error),
    .o_steps_done        (o_steps_done)
  );

  typedef struct {
    int steps;
    int sel;
    int updown;
    int lat;
    bit dead;
    bit hold_start;
    int glitch_at;
    int exp_steps_done;
    bit exp_error;
    int exp_pulses;
    int exp_cycles;
  } vec_t;

  typedef struct {
    int steps_done;
    bit error;
    int pulses;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[7];

  int errors = 0;
  int checks = 0;
  int pll_lat = 4;
  bit pll_dead = 1'b0;
  int pulse_total = 0;
  int width_errs = 0;
  int done_total = 0;
  int sel_exp = 0;
  int ud_exp = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic string nm(input int idx, input string s);
    return $sformatf("r%0d_%s", idx, s);
  endfunction

  // PLL model: phasedone drops when a phasestep pulse starts and stays low for pll_lat cycles.
  initial begin
    bit ps_prev = 1'b0;
    int lo_left = 0;
    i_phasedone = 1'b1;
    forever begin
      @(negedge clk);
      if (o_phasestep && !ps_prev && !pll_dead) begin
        i_phasedone = 1'b0;
        lo_left     = pll_lat;
      end else if (lo_left > 0) begin
        lo_left--;
        if (lo_left == 0) i_phasedone = 1'b1;
      end
      ps_prev = o_phasestep;
    end
  end

  // Output monitor: counts phasestep pulses, pulses not exactly two cycles wide, and done pulses.
  initial begin
    bit ps_prev = 1'b0;
    int run = 0;
    forever begin
      @(posedge clk);
      #1;
      if (o_phasestep) begin
        if (!ps_prev) pulse_total++;
        run++;
      end else begin
        if (ps_prev && run != 2) width_errs++;
        run = 0;
      end
      ps_prev = o_phasestep;
      if (o_done) done_total++;
    end
  end

  task automatic sb_pop(input int idx, input int pulses);
    exp_t e;
    check(nm(idx, "sb_depth"), sb_q.size(), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check(nm(idx, "steps_done"), o_steps_done, e.steps_done);
      check(nm(idx, "error"), o_error, e.error);
      check(nm(idx, "pulses"), pulses, e.pulses);
    end
  endtask

  task automatic run_req(input int idx, input vec_t v);
    int cyc = 0;
    bit seen = 1'b0;
    bit glitched = 1'b0;
    int busy_idle = 0;
    int p0, w0, d0;
    exp_t e;
    p0 = pulse_total;
    w0 = width_errs;
    d0 = done_total;
    pll_lat  = v.lat;
    pll_dead = v.dead;
    if (v.steps != 0) begin
      sel_exp = v.sel;
      ud_exp  = v.updown;
    end
    e.steps_done = v.exp_steps_done;
    e.error      = v.exp_error;
    e.pulses     = v.exp_pulses;
    sb_q.push_back(e);
    i_steps       = 8'(v.steps);
    i_counter_sel = 3'(v.sel);
    i_updown      = 1'(v.updown);
    i_start       = 1'b1;
    while (!seen && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (v.glitch_at > 0 && !glitched && o_phasestep && (pulse_total - p0) == v.glitch_at) begin
        i_start  = 1'b1;
        glitched = 1'b1;
      end else if (!v.hold_start) begin
        i_start = 1'b0;
      end
      if (cyc == 1) check(nm(idx, "busy_on"), o_busy, 1);
      if (o_done) begin
        seen = 1'b1;
        sb_pop(idx, pulse_total - p0);
      end
    end
    check(nm(idx, "done_seen"), seen, 1);
    if (!seen) sb_q.delete();
    if (v.glitch_at > 0) check(nm(idx, "glitch_sent"), glitched, 1);
    if (v.exp_cycles > 0) check(nm(idx, "latency"), cyc, v.exp_cycles);
    check(nm(idx, "sel_pins"), o_phasecounterselect, sel_exp);
    check(nm(idx, "updown_pin"), o_phaseupdown, ud_exp);
    repeat (8) begin
      @(negedge clk);
      if (o_busy) busy_idle++;
    end
    check(nm(idx, "idle_after_done"), busy_idle, 0);
    check(nm(idx, "done_pulses"), done_total - d0, 1);
    check(nm(idx, "width_errs"), width_errs - w0, 0);
    check(nm(idx, "steps_hold"), o_steps_done, v.exp_steps_done);
    check(nm(idx, "error_hold"), o_error, v.exp_error);
    i_start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    bit seen;
    i_rst_n       = 1'b0;
    i_start       = 1'b0;
    i_steps       = '0;
    i_counter_sel = '0;
    i_updown      = 1'b0;

    //          steps sel ud lat dead hold glitch | sdone err pulses cycles
    vecs[0] = '{3,    2,  1, 4,  0,   0,   0,       3,    0,  3,     -1};
    vecs[1] = '{0,    5,  0, 4,  0,   0,   0,       0,    0,  0,      1};
    vecs[2] = '{5,    6,  1, 4,  1,   0,   0,       0,    1,  1,    260};
    vecs[3] = '{4,    1,  0, 4,  0,   0,   2,       4,    0,  4,     -1};
    vecs[4] = '{1,    7,  0, 2,  0,   1,   0,       1,    0,  1,     -1};
    vecs[5] = '{2,    4,  1, 3,  0,   0,   0,       2,    0,  2,     -1};
    vecs[6] = '{255,  3,  1, 1,  0,   0,   0,     255,    0, 255,    -1};

    repeat (3) @(negedge clk);
    check("reset_phasestep", o_phasestep, 0);
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    check("reset_error", o_error, 0);
    check("reset_steps_done", o_steps_done, 0);
    check("reset_sel", o_phasecounterselect, 0);
    check("reset_updown", o_phaseupdown, 0);
    i_rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int r = 0; r < 6; r++) run_req(r, vecs[r]);

    // Reset while a phasestep pulse is in flight.
    pll_lat       = 4;
    pll_dead      = 1'b0;
    i_steps       = 8'd3;
    i_counter_sel = 3'd1;
    i_updown      = 1'b0;
    i_start       = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      i_start = 1'b0;
      if (o_phasestep) seen = 1'b1;
    end
    check("midrst_step_seen", seen, 1);
    i_rst_n = 1'b0;
    @(negedge clk);
    check("midrst_phasestep", o_phasestep, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_done", o_done, 0);
    check("midrst_steps_done", o_steps_done, 0);
    check("midrst_sel", o_phasecounterselect, 0);
    @(negedge clk);
    i_rst_n = 1'b1;
    sel_exp = 0;
    ud_exp  = 0;
    repeat (10) @(negedge clk);

    run_req(6, vecs[6]);

    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
